mem_line_responder: RTL and testbench

MEM_LINE_RESPONDER -- requirements
Module: mem_line_responder

---
 rtl/mem_line_responder_if.sv | 30 +++
 rtl/mem_line_responder.sv | 141 ++++++++++++++
 tb/tb_mem_line_responder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_line_responder_if.sv
// Purpose: handshake and preload bundle between the icache (master) and the line responder (slave).
// Latency: none; wires only.
// Backpressure: request side is valid/ready, response side is valid/ready per beat, preload is fire-and-forget with an error pulse.
// Ports: req_* line-fill request, resp_* response beats, init_* preload write port and drop indication.
interface mem_line_responder_if #(
    parameter int WIDTH = 64
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_addr;
    logic             resp_valid;
    logic             resp_ready;
    logic [WIDTH-1:0] resp_data;
    logic [2:0]       resp_beat;
    logic             resp_last;
    logic             init_we;
    logic [WIDTH-1:0] init_addr;
    logic [WIDTH-1:0] init_data;
    logic             init_err;

    modport master (
        output req_valid, req_addr, resp_ready, init_we, init_addr, init_data,
        input  req_ready, resp_valid, resp_data, resp_beat, resp_last, init_err
    );

    modport slave (
        input  req_valid, req_addr, resp_ready, init_we, init_addr, init_data,
        output req_ready, resp_valid, resp_data, resp_beat, resp_last, init_err
    );
endinterface

// File: rtl/mem_line_responder.sv
// Purpose: backing memory answering icache line fills as 8-beat critical-word-first bursts.
// Latency: first beat LATENCY cycles after request acceptance, then one beat per accepted handshake.
// Backpressure: resp_ready low holds the current beat stable; requests are refused while busy.
// Ports: clk/reset (sync, active-high), bus = slave side of mem_line_responder_if.
module mem_line_responder #(
    parameter int WIDTH    = 64,
    parameter int MEMWORDS = 4096,
    parameter int LATENCY  = 4,
    parameter int BEATS    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mem_line_responder_if.slave  bus
);
    localparam int AW = $clog2(MEMWORDS);
    localparam int LW = AW - 3;

    typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

    state_t           state_q, state_d;
    logic [LW-1:0]    line_q, line_d;
    logic [2:0]       start_q, start_d;
    logic [2:0]       k_q, k_d;
    logic [2:0]       beat_q, beat_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             resp_valid_q, resp_valid_d;
    logic             resp_last_q, resp_last_d;
    logic             init_err_q, init_err_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             mem_we;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic [WIDTH-1:0] mem_q [MEMWORDS];

    // Address bits outside the word index are deliberately ignored (wrap).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.req_addr[WIDTH-1:AW+3], bus.req_addr[2:0],
                                bus.init_addr[WIDTH-1:AW+3], bus.init_addr[2:0]};

    assign wr_idx = bus.init_addr[3 +: AW];

    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        start_d      = start_q;
        k_d          = k_q;
        beat_d       = beat_q;
        cnt_d        = cnt_q;
        resp_valid_d = resp_valid_q;
        resp_last_d  = resp_last_q;
        resp_data_d  = resp_data_q;
        init_err_d   = 1'b0;
        mem_we       = 1'b0;
        rd_idx       = {line_q, beat_q + 3'd1};

        case (state_q)
            IDLE: begin
                // A preload and a request on the same edge both take effect;
                // the read happens later, so the burst sees the new word.
                mem_we = bus.init_we;
                if (bus.req_valid) begin
                    line_d  = bus.req_addr[6 +: LW];
                    start_d = bus.req_addr[5:3];
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                init_err_d = bus.init_we;
                rd_idx     = {line_q, start_q};
                if (cnt_q == 4'd0) begin
                    state_d      = BURST;
                    resp_valid_d = 1'b1;
                    resp_data_d  = mem_q[rd_idx];
                    beat_d       = start_q;
                    k_d          = 3'd0;
                    resp_last_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            BURST: begin
                init_err_d = bus.init_we;
                if (bus.resp_ready) begin
                    if (resp_last_q) begin
                        state_d      = IDLE;
                        resp_valid_d = 1'b0;
                        resp_last_d  = 1'b0;
                    end else begin
                        // Word index wraps inside the line (critical word first).
                        beat_d      = beat_q + 3'd1;
                        k_d         = k_q + 3'd1;
                        resp_data_d = mem_q[rd_idx];
                        resp_last_d = (k_q == 3'(BEATS - 2));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            line_q       <= '0;
            start_q      <= '0;
            k_q          <= '0;
            beat_q       <= '0;
            cnt_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_last_q  <= 1'b0;
            resp_data_q  <= '0;
            init_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            start_q      <= start_d;
            k_q          <= k_d;
            beat_q       <= beat_d;
            cnt_q        <= cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_last_q  <= resp_last_d;
            resp_data_q  <= resp_data_d;
            init_err_q   <= init_err_d;
        end
    end

    // Storage is never reset; contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[wr_idx] <= bus.init_data;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_data  = resp_data_q;
    assign bus.resp_beat  = beat_q;
    assign bus.resp_last  = resp_last_q;
    assign bus.init_err   = init_err_q;
endmodule

// File: tb/tb_mem_line_responder.sv
module tb_mem_line_responder;
    localparam int LATENCY = 4;
    localparam int AW      = 12;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] ref_mem [4096];

    mem_line_responder_if #(.WIDTH(64)) bus ();

    mem_line_responder #(
        .WIDTH(64), .MEMWORDS(4096), .LATENCY(LATENCY), .BEATS(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [63:0] data);
        bus.init_we   = 1'b1;
        bus.init_addr = addr;
        bus.init_data = data;
        tick();
        bus.init_we = 1'b0;
        ref_mem[addr[3 +: AW]] = data;
        check("idle_write_no_err", 64'(bus.init_err), 64'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        check({tag, "_resp_last"},  64'(bus.resp_last),  64'd0);
        check({tag, "_resp_beat"},  64'(bus.resp_beat),  64'd0);
        check({tag, "_resp_data"},  bus.resp_data,       64'd0);
        check({tag, "_init_err"},   64'(bus.init_err),   64'd0);
        check({tag, "_req_ready"},  64'(bus.req_ready),  64'd1);
    endtask

    // One complete line fill; the expected beats come from ref_mem and the
    // critical-word-first rule. Optional: stall, busy-time preload, reset abort,
    // random backpressure, preload on the acceptance edge, first-beat constants.
    task automatic run_burst(input logic [63:0] addr, input int stall_at, input int stall_len,
                             input bit inject, input int abort_after, input bit rand_rdy,
                             input bit wa_en, input logic [63:0] wa_addr, input logic [63:0] wa_data,
                             input bit chk0, input logic [2:0] exp_beat0, input logic [63:0] exp_data0);
        logic [63:0] ed [8];
        logic [2:0]  eb [8];
        int          k;
        int          cyc;
        int          stall_cnt;
        bit          rdy;
        bit          inj_done;
        bit          inj_pending;
        bit          inj_after;
        inj_done    = 1'b0;
        inj_pending = 1'b0;
        inj_after   = 1'b0;
        stall_cnt   = 0;

        check("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid  = 1'b1;
        bus.req_addr   = addr;
        bus.resp_ready = 1'b0;
        if (wa_en) begin
            bus.init_we   = 1'b1;
            bus.init_addr = wa_addr;
            bus.init_data = wa_data;
            ref_mem[wa_addr[3 +: AW]] = wa_data;
        end
        for (int j = 0; j < 8; j++) begin
            eb[j] = 3'((int'(addr[5:3]) + j) % 8);
            ed[j] = ref_mem[{addr[6 +: AW-3], eb[j]}];
        end
        tick();
        bus.init_we = 1'b0;
        // In random mode the icache keeps req_valid up while busy; it must be ignored.
        bus.req_valid = rand_rdy;

        cyc = 0;
        while (bus.resp_valid !== 1'b1 && cyc < 40) begin
            check("wait_req_ready_low", 64'(bus.req_ready), 64'd0);
            tick();
            cyc++;
        end
        check("first_beat_latency", 64'(cyc), 64'(LATENCY));

        k   = 0;
        cyc = 0;
        while (k < 8 && cyc < 200) begin
            check("resp_valid", 64'(bus.resp_valid), 64'd1);
            check("resp_data", bus.resp_data, ed[k]);
            check("resp_beat", 64'(bus.resp_beat), 64'(eb[k]));
            check("resp_last", 64'(bus.resp_last), 64'(k == 7));
            check("busy_req_ready", 64'(bus.req_ready), 64'd0);
            if (chk0 && k == 0) begin
                check("first_beat_const", 64'(bus.resp_beat), 64'(exp_beat0));
                check("first_data_const", bus.resp_data, exp_data0);
            end
            if (k == stall_at && stall_cnt < stall_len) begin
                rdy = 1'b0;
                stall_cnt++;
            end else if (rand_rdy) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
            bus.resp_ready = rdy;
            if (inject && k == 3 && !inj_done) begin
                bus.init_we   = 1'b1;
                bus.init_addr = 64'h48;
                bus.init_data = 64'hDEAD;
                inj_done      = 1'b1;
                inj_pending   = 1'b1;
            end
            if (rdy && k == 7) bus.req_valid = 1'b0;
            tick();
            bus.init_we = 1'b0;
            if (inj_pending) begin
                check("init_err_pulse", 64'(bus.init_err), 64'd1);
                inj_pending = 1'b0;
                inj_after   = 1'b1;
            end else if (inj_after) begin
                check("init_err_one_cycle", 64'(bus.init_err), 64'd0);
                inj_after = 1'b0;
            end
            if (rdy) k++;
            cyc++;
            if (abort_after > 0 && k == abort_after) begin
                bus.req_valid  = 1'b0;
                bus.resp_ready = 1'b1;
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check_reset_outputs("abort");
                tick();
                check("abort_no_more_beats", 64'(bus.resp_valid), 64'd0);
                return;
            end
        end
        bus.resp_ready = 1'b0;
        check("handshake_count", 64'(k), 64'd8);
        check("after_last_valid", 64'(bus.resp_valid), 64'd0);
        check("after_last_req_ready", 64'(bus.req_ready), 64'd1);
    endtask

    typedef struct {
        logic [63:0] addr;
        int          stall_at;
        int          stall_len;
        bit          inject;
        int          abort_after;
        logic [2:0]  exp_beat0;
        logic [63:0] exp_data0;
    } vec_t;

    vec_t vecs [8];

    initial begin
        logic [63:0] a;
        logic [63:0] wa;

        vecs[0] = '{64'h40,   -1, 0, 1'b0, -1, 3'd0, 64'h1008};  // basic fill
        vecs[1] = '{64'h70,   -1, 0, 1'b0, -1, 3'd6, 64'h100E};  // critical word first
        vecs[2] = '{64'h40,    2, 3, 1'b0, -1, 3'd0, 64'h1008};  // 3-cycle stall on beat 2
        vecs[3] = '{64'h40,   -1, 0, 1'b1, -1, 3'd0, 64'h1008};  // preload while busy dropped
        vecs[4] = '{64'h48,   -1, 0, 1'b0, -1, 3'd1, 64'h1009};  // index 9 untouched
        vecs[5] = '{64'h40,   -1, 0, 1'b0,  3, 3'd0, 64'h1008};  // reset after 3 beats
        vecs[6] = '{64'h40,   -1, 0, 1'b0, -1, 3'd0, 64'h1008};  // memory survives reset
        vecs[7] = '{64'h8040, -1, 0, 1'b0, -1, 3'd0, 64'h1008};  // address wrap

        reset          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_addr   = '0;
        bus.resp_ready = 1'b0;
        bus.init_we    = 1'b0;
        bus.init_addr  = '0;
        bus.init_data  = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;

        for (int i = 0; i < 16; i++) do_write(64'(i) << 3, 64'h1000 + 64'(i));
        for (int i = 16; i < 128; i++) do_write(64'(i) << 3, {32'($urandom), 32'($urandom)});

        for (int i = 0; i < 8; i++) begin
            run_burst(vecs[i].addr, vecs[i].stall_at, vecs[i].stall_len, vecs[i].inject,
                      vecs[i].abort_after, 1'b0, 1'b0, 64'd0, 64'd0,
                      1'b1, vecs[i].exp_beat0, vecs[i].exp_data0);
        end

        // Preload on the acceptance edge: the burst must return the new word.
        run_burst(64'h40, -1, 0, 1'b0, -1, 1'b0, 1'b1, 64'h50, 64'hBEEF,
                  1'b1, 3'd0, 64'h1008);

        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 1) == 1) begin
                wa = {32'($urandom), 32'($urandom)};
                wa[14:10] = 5'd0;
                do_write(wa, {32'($urandom), 32'($urandom)});
            end
            a = {32'($urandom), 32'($urandom)};
            a[14:10] = 5'd0;
            wa = {32'($urandom), 32'($urandom)};
            wa[14:10] = 5'd0;
            run_burst(a, -1, 0, 1'b0, -1, 1'b1, ($urandom_range(0, 3) == 0), wa,
                      {32'($urandom), 32'($urandom)}, 1'b0, 3'd0, 64'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
